udm_mult8: RTL and testbench

// - Registered 8x8 unsigned approximate multiplier built on the "underdesigned" 2x2 block.
// - The 2x2 block is exact except for 3x3, which yields 7 (3'b111) instead of 9.
// - The block trades accuracy for area and power. Error-tolerant datapaths (DSP/imaging)

---
 rtl/udm_mult8.sv | 60 ++++++
 tb/tb_udm_mult8.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/udm_mult8.sv
// Registered 8x8 unsigned multiplier built recursively from 2x2 leaves.
// With APPROX set, the leaf returns 7 for 3x3, so the product never exceeds A*B.
module udm_mult8 #(
   parameter int unsigned APPROX = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [7:0]  operand1_i,
   input  logic [7:0]  operand2_i,
   output logic [15:0] result_o
);

   // 2x2 leaf: exact except 3x3 -> 7 in approximate mode (only 3 bits ever set).
   function automatic logic [3:0] m2(input logic [1:0] a, input logic [1:0] b);
      logic [3:0] p;
      p = {2'b00, a} * {2'b00, b};
      if ((APPROX != 0) && (a == 2'd3) && (b == 2'd3)) begin
         p = 4'd7;
      end
      return p;
   endfunction

   function automatic logic [7:0] m4(input logic [3:0] a, input logic [3:0] b);
      logic [7:0] hh;
      logic [7:0] hl;
      logic [7:0] lh;
      logic [7:0] ll;
      hh = {4'b0000, m2(a[3:2], b[3:2])};
      hl = {4'b0000, m2(a[3:2], b[1:0])};
      lh = {4'b0000, m2(a[1:0], b[3:2])};
      ll = {4'b0000, m2(a[1:0], b[1:0])};
      return (hh << 4) + ((hl + lh) << 2) + ll;
   endfunction

   logic [15:0] hh;
   logic [15:0] hl;
   logic [15:0] lh;
   logic [15:0] ll;
   logic [15:0] product_d;
   logic [15:0] result_q;

   always_comb begin
      hh        = {8'h00, m4(operand1_i[7:4], operand2_i[7:4])};
      hl        = {8'h00, m4(operand1_i[7:4], operand2_i[3:0])};
      lh        = {8'h00, m4(operand1_i[3:0], operand2_i[7:4])};
      ll        = {8'h00, m4(operand1_i[3:0], operand2_i[3:0])};
      product_d = (hh << 8) + ((hl + lh) << 4) + ll;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         result_q <= 16'h0000;
      end else begin
         result_q <= product_d;
      end
   end

   assign result_o = result_q;

endmodule

// File: tb/tb_udm_mult8.sv
// Bench for udm_mult8: approximate and exact instances checked every cycle against
// a digit-sum model, plus literal products, reset behaviour and exhaustive sweeps.
module tb_udm_mult8;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  a     = 8'h00;
   logic [7:0]  b     = 8'h00;
   logic [15:0] res_ap;
   logic [15:0] res_ex;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   udm_mult8 #(.APPROX(1)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .operand1_i (a),
      .operand2_i (b),
      .result_o   (res_ap)
   );

   udm_mult8 #(.APPROX(0)) dut_ref (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .operand1_i (a),
      .operand2_i (b),
      .result_o   (res_ex)
   );

   // Product as a weighted sum of all 16 base-4 digit products.
   function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input bit approx);
      int s = 0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            int dx = (int'(x) >> (2 * i)) & 3;
            int dy = (int'(y) >> (2 * j)) & 3;
            int p  = (approx && dx == 3 && dy == 3) ? 7 : dx * dy;
            s += p * (4 ** (i + j));
         end
      end
      return s[15:0];
   endfunction

   function automatic logic [15:0] exact(input logic [7:0] x, input logic [7:0] y);
      return {8'h00, x} * {8'h00, y};
   endfunction

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
      end
   endtask

   logic [15:0] exp_ap = 16'h0000;
   logic [15:0] exp_ex = 16'h0000;
   bit          chk_en = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_ap <= 16'h0000;
         exp_ex <= 16'h0000;
      end else begin
         exp_ap <= model(a, b, 1'b1);
         exp_ex <= exact(a, b);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp_approx", res_ap, exp_ap);
         check("cmp_exact", res_ex, exp_ex);
         total++;
         if (res_ap > exp_ex) begin
            bad++;
            $display("FAIL le_exact got=%h max=%h at %0t", res_ap, exp_ex, $time);
         end
      end
   end

   task automatic apply(input string name, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] want_ap, input logic [15:0] want_ex);
      @(negedge clk);
      a = x;
      b = y;
      @(posedge clk);
      #1;
      check({name, "_ap"}, res_ap, want_ap);
      check({name, "_ex"}, res_ex, want_ex);
   endtask

   initial begin
      // Asynchronous clear before any clock edge.
      #2;
      a     = 8'hA5;
      b     = 8'h5A;
      rst_n = 1'b0;
      #1;
      check("rst_async_ap", res_ap, 16'h0000);
      check("rst_async_ex", res_ex, 16'h0000);
      @(posedge clk);
      #1;
      check("rst_hold_ap", res_ap, 16'h0000);
      @(negedge clk);
      rst_n  = 1'b1;
      a      = 8'h00;
      b      = 8'h00;
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      check("zero_ap", res_ap, 16'h0000);

      apply("x29x7a", 8'h29, 8'h7A, 16'h138A, 16'h138A);
      apply("x11x11", 8'h11, 8'h11, 16'h0121, 16'h0121);
      apply("x55xaa", 8'h55, 8'hAA, 16'h3872, 16'h3872);
      apply("x80x80", 8'h80, 8'h80, 16'h4000, 16'h4000);
      apply("x89xff", 8'h89, 8'hFF, 16'h8877, 16'h8877);
      apply("xabx00", 8'hAB, 8'h00, 16'h0000, 16'h0000);
      apply("x00x01", 8'h00, 8'h01, 16'h0000, 16'h0000);
      apply("x01xff", 8'h01, 8'hFF, 16'h00FF, 16'h00FF);
      apply("x03x03", 8'h03, 8'h03, 16'h0007, 16'h0009);
      apply("x33x33", 8'h33, 8'h33, 16'h07E7, 16'h0A29);
      apply("xffxff", 8'hFF, 8'hFF, 16'hC58F, 16'hFE01);

      // Back-to-back operands, then reset in the middle of the stream.
      apply("pipe0", 8'h44, 8'h3B, 16'h0FAC, 16'h0FAC);
      apply("pipe1", 8'h24, 8'h92, 16'h1488, 16'h1488);
      a = 8'hFF;
      b = 8'hFF;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_ap", res_ap, 16'h0000);
      check("rst_mid_ex", res_ex, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      a     = 8'h29;
      b     = 8'h7A;
      @(posedge clk);
      #1;
      check("resume_ap", res_ap, 16'h138A);
      check("resume_ex", res_ex, 16'h138A);

      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         a = 8'($urandom);
         b = 8'($urandom);
      end

      for (int x = 0; x < 256; x++) begin
         for (int y = 0; y < 256; y++) begin
            @(negedge clk);
            a = 8'(x);
            b = 8'(y);
         end
      end
      @(negedge clk);
      @(negedge clk);
      chk_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
